// File: rtl/ddr_if_2to5_rx.sv
// ddr_if_2to5_rx: receive gearbox for the 5:2 DDR link; aligns on TRAIN_WORD and rebuilds 5-word groups.
module ddr_if_2to5_rx #(
   parameter int               WIDTH      = 14,
   parameter logic [WIDTH-1:0] TRAIN_WORD = 14'h2B5A,
   parameter int               ERR_W      = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   align_req,
   input  logic                   train_en,
   input  logic                   in_valid,
   input  logic [1:0][WIDTH-1:0]  in_data,
   output logic                   out_valid,
   output logic [4:0][WIDTH-1:0]  out_data,
   output logic                   locked,
   output logic                   align_err,
   output logic [ERR_W-1:0]       err_cnt
);
   typedef enum logic {HUNT, LOCKED} state_t;
   state_t                 state_q, state_d;
   logic [2:0]             cnt_q, cnt_d;
   logic [5:0][WIDTH-1:0]  sbuf_q, sbuf_d, ext;
   logic                   out_valid_q, out_valid_d;
   logic [4:0][WIDTH-1:0]  out_data_q, out_data_d;
   logic                   align_err_q, align_err_d;
   logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
   logic [1:0]             rst_sync_q, rst_sync_d;
   logic                   rst_n;
   logic                   grp;
   // Reset asserts asynchronously but is released on a clock edge.
   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) rst_sync_q <= '0;
      else rst_sync_q <= rst_sync_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q     <= HUNT;
         cnt_q       <= '0;
         sbuf_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         align_err_q <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sbuf_q      <= sbuf_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         align_err_q <= align_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sbuf_d      = sbuf_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      align_err_d = 1'b0;
      err_cnt_d   = err_cnt_q;
      ext         = sbuf_q;
      ext[cnt_q]        = in_data[0];
      ext[cnt_q + 3'd1] = in_data[1];
      grp         = cnt_q >= 3'd3;
      if (align_req) begin
         state_d = HUNT;
         cnt_d   = '0;
      end else if (in_valid && state_q == HUNT) begin
         if (in_data[0] == TRAIN_WORD) begin
            sbuf_d[1:0] = in_data;
            cnt_d       = 3'd2;
            state_d     = LOCKED;
         end else if (in_data[1] == TRAIN_WORD) begin
            sbuf_d[0] = in_data[1];
            cnt_d     = 3'd1;
            state_d   = LOCKED;
         end
      end else if (in_valid) begin
         if (!grp) begin
            sbuf_d = ext;
            cnt_d  = cnt_q + 3'd2;
         end else if (train_en && ext[0] != TRAIN_WORD) begin
            state_d     = HUNT;
            cnt_d       = '0;
            align_err_d = 1'b1;
            err_cnt_d   = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
         end else begin
            out_valid_d = 1'b1;
            out_data_d  = ext[4:0];
            sbuf_d      = ext >> (5 * WIDTH);
            cnt_d       = cnt_q - 3'd3;
         end
      end
   end
   always_comb begin
      locked    = state_q == LOCKED;
      out_valid = out_valid_q;
      out_data  = out_data_q;
      align_err = align_err_q;
      err_cnt   = err_cnt_q;
   end
endmodule
